pipe_reg_bank: RTL and testbench
================================

// Module: pipe_reg_bank
// PURPOSE
//  Parametrised bank of pipeline registers with centralised stall/flush control for the cpu pipeline.
//  Replaces the fixed if_id/id_ex/ex_men/men_wb registers with STAGES identical registers.
//  Each register carries a DATA_W payload and a valid bit.
//  Per-stage stall requests freeze upstream registers and insert a bubble; per-stage flush clears registers.
//  Also provides a pc-advance enable and a saturating bubble counter for performance monitoring.
// PARAMETERS
//  DATA_W   32  payload width of every pipeline register
//  STAGES   4   number of pipeline registers, register 0 = if_id ... STAGES-1 = men_wb; range 2..8
//  CNT_W    16  width of bubble_cnt
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               synchronous reset, active-high
//  in_valid   in   1               fetch stage has a valid instruction for register 0
//  d_flat     in   STAGES*DATA_W   next payload; slice k = [k*DATA_W +: DATA_W] feeds register k
//  stall_req  in   STAGES          bit k: logic feeding register k cannot complete this cycle (bit 0 = fetch)
//  flush      in   STAGES          bit k: clear register k at this edge
//  q_flat     out  STAGES*DATA_W   register payloads, same slicing as d_flat
//  q_valid    out  STAGES          register valid bits
//  pc_en      out  1               pc may advance; = ~|stall_req (combinational)
//  hold       out  STAGES          bit k: register k holds this cycle (combinational)
//  bubble_cnt out  CNT_W           count of bubbles inserted, saturating
// BEHAVIOUR
//  - Reset: synchronous, active-high; all q_valid=0, q_flat=0, bubble_cnt=0. Reset beats every other input.
//  - Let m = highest index with stall_req[m]=1. Derived controls:
//    hold[k]   = |stall_req[STAGES-1:k+1]; hold[STAGES-1] = 0.
//    bubble[k] = stall_req[k] & ~hold[k].
//  - Per register k at each rising edge, in priority order:
//    1. rst                -> q=0, v=0
//    2. flush[k]           -> q=0, v=0 (overrides hold and bubble)
//    3. hold[k]            -> q, v unchanged
//    4. bubble[k]          -> q=0, v=0
//    5. otherwise          -> q=d_flat[k], v = (k==0) ? in_valid : q_valid[k-1] (pre-edge value)
//  - Effect: registers below m freeze, register m takes a bubble, registers above m advance. One-cycle latency per register.
//  - Payload is loaded unconditionally in case 5, even when the incoming valid is 0.
//    Downstream logic must qualify the payload with q_valid.
//  - Stalls lasting N cycles insert exactly N bubbles, one per cycle, into register m.
//  - bubble_cnt: +1 on each edge where any bubble[k] applies and neither rst nor flush[k] is active on that register.
//    Several bubbled registers in one cycle still count +1. The counter saturates at all-ones and does not wrap.
//  - Flush with stall in the same cycle: flushed registers clear; unflushed registers follow rules 3-5.
//  - pc_en and hold are purely combinational from stall_req and are independent of rst.
//    The pc already gates itself with its own reset.
//  - A register with v=0 is a bubble; no special encoding is required beyond payload 0.
// TESTING
//  - Reset: hold rst=1 for 2 cycles with random d_flat -> q_valid=0, q_flat=0, bubble_cnt=0.
//  - Flow: DATA_W=32, STAGES=4; in_valid=1, d_flat slice k = 0x100+k, no stalls.
//    -> after 4 cycles q_valid=4'b1111, slice k = 0x100+k.
//  - Single stall: stall_req=4'b0100 for 1 cycle.
//    -> registers 0,1 hold, register 2 v=0, q=0, register 3 advances, pc_en=0, bubble_cnt=1.
//  - Nested stall: stall_req=4'b0110 for 3 cycles -> register 2 bubbles (m=2), register 1 holds; bubble_cnt=3.
//  - Flush vs stall: stall_req=4'b1000 and flush=4'b0011 together.
//    -> registers 0,1 cleared, register 2 holds, register 3 bubbles.
//  - Saturation: CNT_W=2, stall 5 cycles -> bubble_cnt stays 2'b11. Then assert rst mid-stall -> 0 next edge.

Source files
------------

// File: rtl/pipe_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_bank
// Description : Parametrised bank of STAGES identical pipeline registers
//               (register 0 = if_id ... STAGES-1 = men_wb) with centralised
//               stall / flush control, a pc-advance enable and a saturating
//               bubble counter for performance monitoring.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous reset, active-high
//   in_valid   in   1              fetch has a valid instruction for reg 0
//   d_flat     in   STAGES*DATA_W  next payloads, slice k feeds register k
//   stall_req  in   STAGES         bit k: logic feeding register k stalls
//   flush      in   STAGES         bit k: clear register k at this edge
//   q_flat     out  STAGES*DATA_W  register payloads, same slicing as d_flat
//   q_valid    out  STAGES         register valid bits
//   pc_en      out  1              pc may advance (combinational)
//   hold       out  STAGES         bit k: register k holds (combinational)
//   bubble_cnt out  CNT_W          saturating count of inserted bubbles
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_bank #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [STAGES*DATA_W-1:0]   d_flat,
    input  logic [STAGES-1:0]          stall_req,
    input  logic [STAGES-1:0]          flush,
    output logic [STAGES*DATA_W-1:0]   q_flat,
    output logic [STAGES-1:0]          q_valid,
    output logic                       pc_en,
    output logic [STAGES-1:0]          hold,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [STAGES*DATA_W-1:0] r_q;
    logic [STAGES-1:0]        r_valid;
    logic [CNT_W-1:0]         r_bubble_cnt;

    logic [STAGES-1:0]        w_hold;
    logic [STAGES-1:0]        w_bubble;
    logic [STAGES-1:0]        w_valid_in;
    logic                     w_cnt_inc;

    // ------------------------------------------------------------------
    // Stall decode. A register holds whenever any register further down
    // the pipe (higher index) has a stall request; the highest stalled
    // register is the only one that does not hold, and it takes a bubble.
    // Shifting the request vector down by k+1 leaves exactly the bits
    // above k, and naturally yields 0 for the last register.
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_ctrl
            assign w_hold[k] = |(stall_req >> (k + 1));
        end
    endgenerate

    assign w_bubble = stall_req & ~w_hold;

    // Valid chain: register 0 is fed by fetch, register k by register k-1.
    assign w_valid_in = {r_valid[STAGES-2:0], in_valid};

    // A flushed register never counts as a bubble; several bubbles in the
    // same cycle count once.
    assign w_cnt_inc = |(w_bubble & ~flush);

    // ------------------------------------------------------------------
    // Register bank. Priority per register: flush, hold, bubble, advance.
    // The payload is loaded on advance even when the incoming valid is 0;
    // consumers qualify it with q_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            r_valid      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush[s]) begin
                    r_q[s*DATA_W +: DATA_W] <= '0;
                    r_valid[s]              <= 1'b0;
                end else if (w_hold[s]) begin
                    r_q[s*DATA_W +: DATA_W] <= r_q[s*DATA_W +: DATA_W];
                    r_valid[s]              <= r_valid[s];
                end else if (w_bubble[s]) begin
                    r_q[s*DATA_W +: DATA_W] <= '0;
                    r_valid[s]              <= 1'b0;
                end else begin
                    r_q[s*DATA_W +: DATA_W] <= d_flat[s*DATA_W +: DATA_W];
                    r_valid[s]              <= w_valid_in[s];
                end
            end

            if (w_cnt_inc && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
        end
    end

    // pc_en and hold ignore rst: the pc already gates itself on reset.
    assign pc_en      = ~|stall_req;
    assign hold       = w_hold;
    assign q_flat     = r_q;
    assign q_valid    = r_valid;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_bank
// Description : Scoreboard bench for pipe_reg_bank. Two instances share all
//               inputs: a 16-bit-counter instance for the datapath and a
//               2-bit-counter instance for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_bank;

    localparam int DATA_W = 32;
    localparam int STAGES = 4;

    localparam logic [127:0] D1 = {32'h103, 32'h102, 32'h101, 32'h100};
    localparam logic [127:0] D2 = {32'h203, 32'h202, 32'h201, 32'h200};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] d_flat;
    logic [3:0]   stall_req;
    logic [3:0]   flush;

    logic [127:0] q_flat,  q_flat2;
    logic [3:0]   q_valid, q_valid2;
    logic         pc_en,   pc_en2;
    logic [3:0]   hold,    hold2;
    logic [15:0]  bubble_cnt;
    logic [1:0]   bubble_cnt2;

    typedef struct {
        logic [127:0] q;
        logic [3:0]   v;
        logic [15:0]  cnt;
        logic [1:0]   cnt2;
        logic [3:0]   hold;
        logic         pc_en;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_reg_bank #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_flat(d_flat),
        .stall_req(stall_req), .flush(flush), .q_flat(q_flat),
        .q_valid(q_valid), .pc_en(pc_en), .hold(hold), .bubble_cnt(bubble_cnt)
    );

    pipe_reg_bank #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_flat(d_flat),
        .stall_req(stall_req), .flush(flush), .q_flat(q_flat2),
        .q_valid(q_valid2), .pc_en(pc_en2), .hold(hold2), .bubble_cnt(bubble_cnt2)
    );

    task automatic check(input string name, input int step_no,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic r, input logic iv, input logic [127:0] d,
                        input logic [3:0] st, input logic [3:0] fl,
                        input logic [127:0] eq, input logic [3:0] ev,
                        input logic [15:0] ec, input logic [1:0] ec2,
                        input logic [3:0] eh, input logic epc);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; d_flat = d; stall_req = st; flush = fl;
        e.q = eq; e.v = ev; e.cnt = ec; e.cnt2 = ec2; e.hold = eh; e.pc_en = epc;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: the bank presents a new state every cycle.
    initial begin : monitor
        int step_no = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q_flat",      step_no, q_flat,             e.q);
                check("q_valid",     step_no, {124'd0, q_valid},  {124'd0, e.v});
                check("bubble_cnt",  step_no, {112'd0, bubble_cnt}, {112'd0, e.cnt});
                check("bubble_cnt2", step_no, {126'd0, bubble_cnt2}, {126'd0, e.cnt2});
                check("hold",        step_no, {124'd0, hold},     {124'd0, e.hold});
                check("pc_en",       step_no, {127'd0, pc_en},    {127'd0, e.pc_en});
                step_no++;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; in_valid = 1'b0; d_flat = '0; stall_req = '0; flush = '0;

        // Reset with random payload
        for (int i = 0; i < 2; i++)
            step(1, 1, {$urandom, $urandom, $urandom, $urandom}, 4'b0000, 4'b0000,
                 128'd0, 4'b0000, 16'd0, 2'd0, 4'b0000, 1'b1);

        // Flow: payload loads everywhere immediately, valid ripples in
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b0001, 16'd0, 2'd0, 4'b0000, 1'b1);
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b0011, 16'd0, 2'd0, 4'b0000, 1'b1);
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b0111, 16'd0, 2'd0, 4'b0000, 1'b1);
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b1111, 16'd0, 2'd0, 4'b0000, 1'b1);

        // Single stall at register 2
        step(0, 1, D2, 4'b0100, 4'b0000, {32'h203, 32'h0, 32'h101, 32'h100},
             4'b1011, 16'd1, 2'd1, 4'b0011, 1'b0);

        // Nested stall 0110 for 3 cycles: m=2 bubbles, 0/1 hold
        step(0, 1, D2, 4'b0110, 4'b0000, {32'h203, 32'h0, 32'h101, 32'h100},
             4'b0011, 16'd2, 2'd2, 4'b0011, 1'b0);
        step(0, 1, D2, 4'b0110, 4'b0000, {32'h203, 32'h0, 32'h101, 32'h100},
             4'b0011, 16'd3, 2'd3, 4'b0011, 1'b0);
        step(0, 1, D2, 4'b0110, 4'b0000, {32'h203, 32'h0, 32'h101, 32'h100},
             4'b0011, 16'd4, 2'd3, 4'b0011, 1'b0);

        // Release
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b0111, 16'd4, 2'd3, 4'b0000, 1'b1);
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b1111, 16'd4, 2'd3, 4'b0000, 1'b1);

        // Flush 0011 with stall at register 3
        step(0, 1, D2, 4'b1000, 4'b0011, {32'h0, 32'h102, 32'h0, 32'h0},
             4'b0100, 16'd5, 2'd3, 4'b0111, 1'b0);

        // Flush on the bubbled register: no bubble counted
        step(0, 1, D2, 4'b0100, 4'b0100, {32'h203, 32'h0, 32'h0, 32'h0},
             4'b1000, 16'd5, 2'd3, 4'b0011, 1'b0);

        // in_valid low: payload still loads, valids drain
        step(0, 0, D1, 4'b0000, 4'b0000, D1, 4'b0000, 16'd5, 2'd3, 4'b0000, 1'b1);
        step(0, 1, D1, 4'b0000, 4'b0000, D1, 4'b0001, 16'd5, 2'd3, 4'b0000, 1'b1);

        // Fetch stall only: register 0 bubbles, everything else advances
        step(0, 1, D2, 4'b0001, 4'b0000, {32'h203, 32'h202, 32'h201, 32'h0},
             4'b0010, 16'd6, 2'd3, 4'b0000, 1'b0);

        // Long stall: wide counter keeps counting, narrow one stays saturated
        for (int i = 0; i < 5; i++)
            step(0, 1, D2, 4'b0100, 4'b0000, {32'h203, 32'h0, 32'h201, 32'h0},
                 4'b0010, 16'(7 + i), 2'd3, 4'b0011, 1'b0);

        // Reset mid-stall: counters clear, hold/pc_en still follow stall_req
        step(1, 1, D2, 4'b0100, 4'b0000, 128'd0, 4'b0000, 16'd0, 2'd0, 4'b0011, 1'b0);
        step(0, 1, D2, 4'b0100, 4'b0000, {32'h203, 32'h0, 32'h0, 32'h0},
             4'b0000, 16'd1, 2'd1, 4'b0011, 1'b0);

        @(negedge clk);
        stall_req = '0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
